wb_sram_arb2: RTL and testbench
===============================

Name: wb_sram_arb2

Overview:
- Two-port Wishbone arbiter that shares one wb_sram16 slave between two masters: port 0 is the CPU data bus, port 1 is DMA or video fetch.
- Round-robin grant, held for the whole bus cycle (while cyc stays high).
- Built-in watchdog returns err if the slave never acks.
- Sits directly in front of the SRAM controller; all traffic is 32-bit words.

Parameters:
- timeout, 255, cycles a granted strobe may wait for ack before err; 0 disables the watchdog.
- to_width, 8, width of the watchdog counter; timeout must be below 2**to_width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous reset, active-high.
- m0_stb_i, m0_cyc_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_adr_i  in  32  master 0 byte address.
- m0_sel_i  in  4  master 0 byte selects.
- m0_dat_i  in  32  master 0 write data.
- m0_dat_o  out  32  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 terminations.
- m1_*  same set as m0_*, for master 1.
- s_stb_o, s_cyc_o, s_we_o  out  1 each  to SRAM controller.
- s_adr_o  out  32  to SRAM controller.
- s_sel_o  out  4  to SRAM controller.
- s_dat_o  out  32  to SRAM controller.
- s_dat_i  in  32  from SRAM controller.
- s_ack_i  in  1  from SRAM controller.

Behaviour:
- Clock and reset are clk and reset. One clock domain; reset is asynchronous and active-high.
- States: IDLE, GNT0, GNT1. State, last-grant flag and watchdog counter are registers.
- Reset: state=IDLE, last=1 (so port 0 wins the first tie), counter=0.
- Output values during reset: all s_* controls 0, all m*_ack_o and m*_err_o 0.
- reqN = mN_cyc_i & mN_stb_i.
- IDLE transitions:
  - Only req0 → GNT0. Only req1 → GNT1.
  - Both → grant the port != last.
  - None → stay IDLE.
  - On entering GNTn: last <= n, counter <= 0.
- Decision latency: one clock from request to the granted strobe appearing at the slave.
- GNTn datapath (combinational from the registered state):
  - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o = master n's inputs.
  - mn_ack_o = s_ack_i.
  - Other master: ack=0, err=0.
  - Both m*_dat_o = s_dat_i at all times.
- In IDLE all s_* control outputs are 0 and s_ack_i is discarded, including stale acks after a timeout.
- Grant is released when the granted master drops cyc: GNTn → IDLE.
  - There is always at least one IDLE cycle between grants, so the slave sees stb low before the next requester.
- Back-to-back transfers with cyc held keep the grant indefinitely; the other port waits. This is intended (bursts/locked sequences).
- Watchdog, active in GNTn with stb high and timeout != 0:
  - Counter increments each cycle without ack; clears on ack or when stb is low.
  - When counter == timeout and no ack: mn_err_o=1 for exactly that cycle, s_stb_o/s_cyc_o forced 0 that cycle, next state IDLE.
  - Counter saturates; it never wraps.
- Simultaneous events:
  - An ack arriving in the same cycle as a timeout wins: ack=1, err=0.
  - Master dropping cyc in the same cycle as an ack → IDLE.
  - A request from the other port during GNTn is simply held off.
- Reset mid-transfer: outputs drop to 0 immediately (asynchronously).
  - The slave may still complete its current SRAM access. Its ack lands in IDLE and is discarded.

Decomposition:
- Shared package wb_arb_pkg: state encodings (S_IDLE=0, S_GNT0=1, S_GNT1=2), ADR_W=32, DAT_W=32, SEL_W=4.
- One natural sub-module, wb_arb_watchdog: counter, saturate, clear and err-pulse logic, parameterised by timeout/to_width.
- The request/grant FSM and the muxes stay in the top module.

Test Plan:
- Single read: m0 reads 0x00000100, slave returns 0xDEADBEEF after 3 cycles → s_stb_o rises 1 cycle after req0; m0_ack_o=1 with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- Round-robin: req0 and req1 both asserted from reset, each does 1 word and drops cyc → grant order 0,1,0,1; exactly 1 IDLE cycle between grants; both ports get 2 acks in 4 transactions.
- Burst hold: m0 holds cyc for 4 writes (sel=0xF, data 0x11111111..0x44444444) while m1 requests → m1 is granted only after m0 drops cyc; slave sees all 4 writes with correct sel and data.
- Timeout: timeout=5, slave never acks m1 → m1_err_o pulses once, 6 cycles after the grant; s_stb_o=0 that cycle; FSM returns to IDLE; a pending m0 request is granted next.
- Ack-vs-timeout collision: slave acks exactly on the cycle counter==timeout → ack=1, err=0.
- Async reset asserted mid-read: s_cyc_o/s_stb_o drop to 0 before the next clock edge; after release, a late s_ack_i in IDLE produces no m*_ack_o; port 0 wins the next tie.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encodings and bus widths for the two-port SRAM arbiter
package wb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - saturating strobe-to-ack watchdog with a one-cycle err pulse
module wb_arb_watchdog #(
    parameter int unsigned timeout  = 255,
    parameter int unsigned to_width = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic err
);

    localparam logic [to_width-1:0] TO_VAL  = to_width'(timeout);
    localparam logic [to_width-1:0] CNT_MAX = '1;
    localparam logic [to_width-1:0] CNT_ONE = to_width'(1);
    localparam bit                  ENABLED = (timeout != 0);

    logic [to_width-1:0] cnt_q;

    // Counts only while a granted strobe waits; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || !active || ack) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // An ack in the expiry cycle wins over the timeout.
    assign err = ENABLED && active && !ack && (cnt_q == TO_VAL);

endmodule

// File: rtl/wb_sram_arb2.sv
// rtl/wb_sram_arb2.sv - round-robin two-master Wishbone arbiter in front of one SRAM slave
module wb_sram_arb2
    import wb_arb_pkg::*;
#(
    parameter int unsigned timeout  = 255,
    parameter int unsigned to_width = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic             s_stb_o,
    output logic             s_cyc_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i
);

    arb_state_t state_q, state_d;
    logic       last_q;
    logic       req0, req1;
    logic       wd_active, wd_clear, wd_err;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    assign wd_active = ((state_q == S_GNT0) && m0_stb_i) ||
                       ((state_q == S_GNT1) && m1_stb_i);
    assign wd_clear  = (state_q == S_IDLE);

    wb_arb_watchdog #(
        .timeout  (timeout),
        .to_width (to_width)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .active (wd_active),
        .ack    (s_ack_i),
        .err    (wd_err)
    );

    // last_q starts at 1 so port 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_GNT0) begin
                last_q <= 1'b0;
            end else if (state_q == S_IDLE && state_d == S_GNT1) begin
                last_q <= 1'b1;
            end
        end
    end

    // Grants only leave through IDLE, so the slave always sees stb low between owners.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? S_GNT0 : S_GNT1;
                end else if (req0) begin
                    state_d = S_GNT0;
                end else if (req1) begin
                    state_d = S_GNT1;
                end
            end
            S_GNT0: begin
                if (!m0_cyc_i || wd_err) begin
                    state_d = S_IDLE;
                end
            end
            S_GNT1: begin
                if (!m1_cyc_i || wd_err) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The expiring cycle withdraws the strobe so the slave does not start a late access.
    always_comb begin
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            S_GNT0: begin
                s_stb_o  = m0_stb_i & ~wd_err;
                s_cyc_o  = m0_cyc_i & ~wd_err;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = wd_err;
            end
            S_GNT1: begin
                s_stb_o  = m1_stb_i & ~wd_err;
                s_cyc_o  = m1_cyc_i & ~wd_err;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = wd_err;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_sram_arb2.sv
// tb/tb_wb_sram_arb2.sv - directed vector bench for wb_sram_arb2
module tb_wb_sram_arb2;

    localparam int unsigned TIMEOUT = 5;
    localparam logic [31:0] ADR0 = 32'h0000_0100;
    localparam logic [31:0] ADR1 = 32'h0000_0200;

    logic        clk, reset;
    logic        m0_stb_i, m0_cyc_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic        m1_stb_i, m1_cyc_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;

    int checks = 0;
    int errors = 0;

    wb_sram_arb2 #(.timeout(TIMEOUT), .to_width(8)) dut (
        .clk(clk), .reset(reset),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic        ack;
        logic [31:0] sdat;
        logic        e_stb;
        logic [1:0]  e_src;
        logic        e_ack0;
        logic        e_ack1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                                input logic ack, input logic [31:0] sdat,
                                input logic e_stb, input logic [1:0] e_src,
                                input logic e_ack0, input logic e_ack1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.ack = ack; v.sdat = sdat;
        v.e_stb = e_stb; v.e_src = e_src; v.e_ack0 = e_ack0; v.e_ack1 = e_ack1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic r0, input logic r1);
        m0_cyc_i = r0; m0_stb_i = r0;
        m1_cyc_i = r1; m1_stb_i = r1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        set_req(1'b0, 1'b0);
        s_ack_i = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] src_adr(input logic [1:0] src);
        case (src)
            2'd1:    return ADR0;
            2'd2:    return ADR1;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        m0_we_i = 0; m0_adr_i = ADR0; m0_sel_i = 4'h0; m0_dat_i = 0;
        m1_we_i = 0; m1_adr_i = ADR1; m1_sel_i = 4'h0; m1_dat_i = 0;
        s_dat_i = 0; s_ack_i = 0;
        set_req(1'b1, 1'b0);
        s_ack_i = 1'b1;

        // Reset state: requests and ack present, yet everything held low
        #12;
        chk("rst s_stb", s_stb_o, 0);
        chk("rst s_cyc", s_cyc_o, 0);
        chk("rst m0_ack", m0_ack_o, 0);
        chk("rst m1_ack", m1_ack_o, 0);
        chk("rst errs", {m0_err_o, m1_err_o}, 0);
        next_cycle();

        // Single read with 3-cycle slave latency
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'hDEADBEEF, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0));
        // Round-robin from reset, grant order 0,1,0,1
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hA0A0A0A0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hB1B1B1B1, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'hA2A2A2A2, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hB3B3B3B3, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            set_req(vecs[i].r0, vecs[i].r1);
            s_ack_i = vecs[i].ack;
            s_dat_i = vecs[i].sdat;
            @(negedge clk);
            chk($sformatf("v%0d s_stb", i), s_stb_o, vecs[i].e_stb);
            chk($sformatf("v%0d s_cyc", i), s_cyc_o, vecs[i].e_stb);
            chk($sformatf("v%0d s_adr", i), s_adr_o, src_adr(vecs[i].e_src));
            chk($sformatf("v%0d m0_ack", i), m0_ack_o, vecs[i].e_ack0);
            chk($sformatf("v%0d m1_ack", i), m1_ack_o, vecs[i].e_ack1);
            chk($sformatf("v%0d errs", i), {m0_err_o, m1_err_o}, 0);
            chk($sformatf("v%0d m0_dat", i), m0_dat_o, vecs[i].sdat);
            chk($sformatf("v%0d m1_dat", i), m1_dat_o, vecs[i].sdat);
            next_cycle();
        end

        // Burst hold: m0 writes 4 words with cyc held while m1 waits
        pulse_reset();
        set_req(1'b1, 1'b1);
        m0_we_i = 1'b1; m0_sel_i = 4'hF;
        @(negedge clk);
        chk("burst idle s_stb", s_stb_o, 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            m0_adr_i = ADR0 + 32'(4 * i);
            m0_dat_i = 32'h11111111 * 32'(i + 1);
            s_ack_i = 1'b1;
            @(negedge clk);
            chk($sformatf("burst%0d s_stb", i), s_stb_o, 1);
            chk($sformatf("burst%0d s_we", i), s_we_o, 1);
            chk($sformatf("burst%0d s_sel", i), s_sel_o, 4'hF);
            chk($sformatf("burst%0d s_dat", i), s_dat_o, 32'h11111111 * 32'(i + 1));
            chk($sformatf("burst%0d s_adr", i), s_adr_o, ADR0 + 32'(4 * i));
            chk($sformatf("burst%0d acks", i), {m0_ack_o, m1_ack_o}, 2'b10);
            next_cycle();
        end
        set_req(1'b0, 1'b1);
        m0_we_i = 1'b0; m0_sel_i = 4'h0; m0_adr_i = ADR0; s_ack_i = 1'b0;
        @(negedge clk);
        chk("burst drop s_cyc", s_cyc_o, 0);
        next_cycle();
        @(negedge clk);
        chk("burst gap s_stb", s_stb_o, 0);
        chk("burst gap s_adr", s_adr_o, 0);
        next_cycle();
        @(negedge clk);
        chk("burst m1 s_stb", s_stb_o, 1);
        chk("burst m1 s_adr", s_adr_o, ADR1);
        next_cycle();

        // Watchdog: slave never acks m1, m0 request pending
        pulse_reset();
        set_req(1'b0, 1'b1);
        @(negedge clk);
        chk("to idle s_stb", s_stb_o, 0);
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) set_req(1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("to%0d m1_err", k), m1_err_o, (k == 6));
            chk($sformatf("to%0d s_stb", k), s_stb_o, (k != 6));
            chk($sformatf("to%0d s_cyc", k), s_cyc_o, (k != 6));
            chk($sformatf("to%0d s_adr", k), s_adr_o, ADR1);
            chk($sformatf("to%0d m0_ack", k), m0_ack_o, 0);
            next_cycle();
        end
        set_req(1'b1, 1'b0);
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("to stale s_stb", s_stb_o, 0);
        chk("to stale acks", {m0_ack_o, m1_ack_o}, 0);
        chk("to stale errs", {m0_err_o, m1_err_o}, 0);
        next_cycle();
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("to m0 s_adr", s_adr_o, ADR0);
        chk("to m0 s_stb", s_stb_o, 1);
        next_cycle();

        // Ack on the exact expiry cycle beats the timeout
        pulse_reset();
        set_req(1'b1, 1'b0);
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            s_ack_i = (k == 6);
            @(negedge clk);
            chk($sformatf("col%0d m0_err", k), m0_err_o, 0);
            chk($sformatf("col%0d m0_ack", k), m0_ack_o, (k == 6));
            chk($sformatf("col%0d s_stb", k), s_stb_o, 1);
            next_cycle();
        end
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("col after s_stb", s_stb_o, 1);
        chk("col after m0_err", m0_err_o, 0);
        next_cycle();
        set_req(1'b0, 1'b0);
        @(negedge clk);
        chk("col drop s_stb", s_stb_o, 0);
        next_cycle();
        next_cycle();

        // Asynchronous reset mid-read, then late ack and tie after release
        set_req(1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("ar granted s_stb", s_stb_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar async s_stb", s_stb_o, 0);
        chk("ar async s_cyc", s_cyc_o, 0);
        set_req(1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("ar late acks", {m0_ack_o, m1_ack_o}, 0);
        chk("ar late s_stb", s_stb_o, 0);
        next_cycle();
        s_ack_i = 1'b0;
        set_req(1'b1, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("ar tie s_adr", s_adr_o, ADR0);
        chk("ar tie s_stb", s_stb_o, 1);
        next_cycle();
        set_req(1'b0, 1'b0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
